// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown with internal prescaler; COUNTDOWN_BLINK_EN adds a blinking blank in DONE.
// All outputs registered, one-cycle response to inputs; no backpressure, controls are level-sampled.
module bcd_countdown_timer #(
  parameter int         TICK_DIV = 50000000,
  parameter logic [15:0] PRESET  = 16'h5959,
  parameter bit         WRAP     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        tick,
  output logic        blank
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   digits_dec;
  logic          load_ok;

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
           (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  // Borrow ripples only while the lower digit was zero; 00:00 rolls to 59:59.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = (mt != 4'd0) ? mt - 4'd1 : 4'd5;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign digits_dec = bcd_dec(digits);
  assign load_ok    = load && (state != RUN) && bcd_valid(load_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= PRESET;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      tick    <= 1'b0;
      blank   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load_ok) begin
        state   <= IDLE;
        digits  <= load_value;
        presc   <= '0;
        running <= 1'b0;
        expired <= 1'b0;
        blank   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (digits == 16'h0000) begin
                state   <= DONE;
                expired <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
                presc   <= '0;
              end
            end
          end
          RUN: begin
            expired <= 1'b0;
            if (pause) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else if (presc == TERM) begin
              presc  <= '0;
              tick   <= 1'b1;
              digits <= digits_dec;
              if (digits_dec == 16'h0000) begin
                expired <= 1'b1;
                if (!WRAP) begin
                  state   <= DONE;
                  running <= 1'b0;
                end
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            // Prescaler stays frozen so the sub-second phase survives the pause.
            if (!pause && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
`ifdef COUNTDOWN_BLINK_EN
            if (presc == TERM) begin
              presc <= '0;
              blank <= ~blank;
            end else begin
              presc <= presc + 1'b1;
            end
`else
            presc <= '0;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed table, hand sequences and random stimulus vs a seconds-based model.
module tb_bcd_countdown_timer;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, pause, load;
  logic [15:0] load_value;
  logic [15:0] digits0, digits1;
  logic        running0, expired0, tick0, blank0;
  logic        running1, expired1, tick1, blank1;

  bcd_countdown_timer #(.TICK_DIV(TD), .PRESET(16'h5959), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .load_value(load_value), .digits(digits0), .running(running0),
    .expired(expired0), .tick(tick0), .blank(blank0)
  );

  bcd_countdown_timer #(.TICK_DIV(TD), .PRESET(16'h5959), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .load_value(load_value), .digits(digits1), .running(running1),
    .expired(expired1), .tick(tick1), .blank(blank1)
  );

  int nvec  = 0;
  int nfail = 0;

  // Reference model: time kept as total seconds, phase as cycles into the current second.
  typedef struct {
    int mode;
    int secs;
    int phase;
    bit running;
    bit expired;
    bit tick;
    bit blank;
  } model_t;

  model_t mdl[2];

  typedef struct {
    bit          rst, st, ps, ld;
    logic [15:0] lv;
    logic [15:0] dig;
    bit          run, exp, tck;
  } vec_t;

  vec_t tbl[$];

  function automatic int bcd_to_secs(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit lv_ok(input logic [15:0] v);
    return int'(v[15:12]) <= 5 && int'(v[11:8]) <= 9 && int'(v[7:4]) <= 5 && int'(v[3:0]) <= 9;
  endfunction

  function automatic model_t mstep(input model_t m, input bit wrap, input logic rst,
                                   input logic st, input logic ps, input logic ld,
                                   input logic [15:0] lv);
    model_t n;
    n = m;
    n.tick = 1'b0;
    if (rst) begin
      n.mode = M_IDLE; n.secs = bcd_to_secs(16'h5959); n.phase = 0;
      n.running = 0; n.expired = 0; n.blank = 0;
      return n;
    end
    if (ld && m.mode != M_RUN && lv_ok(lv)) begin
      n.mode = M_IDLE; n.secs = bcd_to_secs(lv); n.phase = 0;
      n.running = 0; n.expired = 0; n.blank = 0;
      return n;
    end
    case (m.mode)
      M_IDLE: if (st) begin
        if (m.secs == 0) begin
          n.mode = M_DONE; n.expired = 1;
        end else begin
          n.mode = M_RUN; n.running = 1; n.phase = 0;
        end
      end
      M_RUN: begin
        n.expired = 0;
        if (ps) begin
          n.mode = M_PAUSE; n.running = 0;
        end else if (m.phase == TD - 1) begin
          n.phase = 0;
          n.tick = 1;
          n.secs = (m.secs + 3599) % 3600;
          if (n.secs == 0) begin
            n.expired = 1;
            if (!wrap) begin
              n.mode = M_DONE; n.running = 0;
            end
          end
        end else begin
          n.phase = m.phase + 1;
        end
      end
      M_PAUSE: if (!ps && st) begin
        n.mode = M_RUN; n.running = 1;
      end
      default: begin
`ifdef COUNTDOWN_BLINK_EN
        n.phase = (m.phase + 1) % TD;
        if (m.phase == TD - 1) n.blank = !m.blank;
`else
        n.phase = 0;
`endif
      end
    endcase
    return n;
  endfunction

  task automatic drive(input bit r, input bit s, input bit p, input bit l, input logic [15:0] v);
    reset = r; start = s; pause = p; load = l; load_value = v;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_model(input int k);
    logic [19:0] got, exp;
    exp = {secs_to_bcd(mdl[k].secs), mdl[k].running, mdl[k].expired, mdl[k].tick, mdl[k].blank};
    if (k == 0) got = {digits0, running0, expired0, tick0, blank0};
    else        got = {digits1, running1, expired1, tick1, blank1};
    chk(k == 0 ? "model_wrap0" : "model_wrap1", 32'(got), 32'(exp));
  endtask

  // One clock: advance both models on the inputs now applied, then compare after the edge.
  task automatic cycle();
    model_t nx0, nx1;
    nx0 = mstep(mdl[0], 1'b0, reset, start, pause, load, load_value);
    nx1 = mstep(mdl[1], 1'b1, reset, start, pause, load, load_value);
    @(posedge clk);
    #1;
    mdl[0] = nx0;
    mdl[1] = nx1;
    check_model(0);
    check_model(1);
  endtask

  task automatic add(input bit r, input bit s, input bit p, input bit l, input logic [15:0] v,
                     input logic [15:0] d, input bit ru, input bit ex, input bit tk);
    vec_t t;
    t.rst = r; t.st = s; t.ps = p; t.ld = l; t.lv = v;
    t.dig = d; t.run = ru; t.exp = ex; t.tck = tk;
    tbl.push_back(t);
  endtask

  task automatic add_hold(input int n, input logic [15:0] d, input bit ru, input bit ex);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 16'h0, d, ru, ex, 0);
  endtask

  initial begin
    logic [15:0] lv;
    logic        exp_blank;

    // Countdown 0003 to expiry, then hold in DONE
    add(1, 0, 0, 0, 16'h0000, 16'h5959, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0003, 16'h0003, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0);
    add_hold(3, 16'h0003, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 1);
    add_hold(3, 16'h0002, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 1);
    add_hold(3, 16'h0001, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
    add_hold(20, 16'h0000, 0, 1);
    // Borrow through minutes, invalid loads, blocked load in RUN, load from PAUSE
    add(0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0A00, 16'h1000, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0060, 16'h1000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0);
    add_hold(3, 16'h1000, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0959, 1, 0, 1);
    add(0, 0, 0, 1, 16'h1234, 16'h0959, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0000, 16'h0959, 0, 0, 0);
    add(0, 0, 0, 1, 16'h1234, 16'h1234, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0100, 1, 0, 0);
    add_hold(3, 16'h0100, 1, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 1);
    // Pause after two RUN cycles, resume: two more cycles to the next tick
    add_hold(2, 16'h0059, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 16'h0000, 16'h0059, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0059, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 16'h0058, 1, 0, 1);
    // Reset with start held, start+pause in RUN, start on 0000
    add(1, 1, 0, 0, 16'h0000, 16'h5959, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h5959, 1, 0, 0);
    add(0, 1, 1, 0, 16'h0000, 16'h5959, 0, 0, 0);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 1, 16'h0001, 16'h0001, 0, 0, 0);

    drive(1, 0, 0, 0, 16'h0000);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].ps, tbl[i].ld, tbl[i].lv);
      cycle();
      chk($sformatf("row%0d", i), {12'h0, digits0, 1'b0, running0, expired0, tick0},
          {12'h0, tbl[i].dig, 1'b0, tbl[i].run, tbl[i].exp, tbl[i].tck});
    end

    // 0001 on both: WRAP=1 goes through 0000 to 5959 while WRAP=0 expires and sits in DONE
    drive(1, 0, 0, 0, 16'h0000); cycle();
    drive(0, 0, 0, 1, 16'h0001); cycle();
    drive(0, 1, 0, 0, 16'h0000); cycle();
    drive(0, 0, 0, 0, 16'h0000);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (i <= 8) begin
        chk($sformatf("wrap_digits%0d", i), 32'(digits1),
            32'(i < 4 ? 16'h0001 : (i < 8 ? 16'h0000 : 16'h5959)));
        chk($sformatf("wrap_flags%0d", i), {29'h0, running1, expired1, tick1},
            {29'h0, 1'b1, (i == 4) ? 1'b1 : 1'b0, (i == 4 || i == 8) ? 1'b1 : 1'b0});
      end
`ifdef COUNTDOWN_BLINK_EN
      exp_blank = (i >= 4) ? 1'(((i - 4) / 4) % 2) : 1'b0;
`else
      exp_blank = 1'b0;
`endif
      chk($sformatf("blank%0d", i), 32'(blank0), 32'(exp_blank));
    end
    drive(0, 0, 0, 1, 16'h0005); cycle();
    chk("blank_load_clear", {30'h0, blank0, expired0}, 32'h0);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    lv = secs_to_bcd(int'($urandom_range(0, 6)));
        2:       lv = secs_to_bcd(int'($urandom_range(0, 3599)));
        default: lv = 16'($urandom);
      endcase
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, lv);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised MM:SS BCD countdown timer with run/pause control, loadable preset, expiry detection and optional wrap-around. An internal prescaler generates the per-second tick, so no external clock divider is needed. Four BCD digits are presented as one bus that feeds the existing 4-digit seven-segment driver directly. The block sits between the board-level buttons and `SegDisplay`.

## Interface
- `TICK_DIV`, default 50000000: clk cycles per count step; must be ≥2; prescaler width is `$clog2(TICK_DIV)`.
- `PRESET`, default 16'h5959: BCD value loaded at reset, as {min_tens, min_ones, sec_tens, sec_ones}.
- `WRAP`, default 0:
  - 0: stop at 00:00.
  - 1: continue 00:00 → 59:59.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sampled; start or resume counting.
- `pause` in 1: level-sampled; hold count.
- `load` in 1: load `load_value`.
- `load_value` in 16: BCD preset, same packing as `PRESET`.
- `digits` out 16: current BCD value; [3:0] is seconds ones.
- `running` out 1: high in RUN.
- `expired` out 1: expiry indication (see Operation).
- `tick` out 1: one-cycle pulse on every count step.
- `blank` out 1: display blank request (see Configuration).

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset state: IDLE.
- Reset values:
  - `digits` = `PRESET`.
  - Prescaler = 0.
  - `running`, `expired`, `tick`, `blank` = 0.
- IDLE:
  - `start` → RUN, prescaler cleared.
  - If `digits` = 0000 at `start`: go to DONE instead, and `expired` = 1.
- RUN:
  - Prescaler counts 0..`TICK_DIV`-1.
  - At terminal count: prescaler wraps to 0, `tick` pulses, `digits` decrements.
  - `pause` → PAUSE.
- PAUSE:
  - Prescaler and `digits` are frozen.
  - `start` → RUN, resuming from the frozen prescaler value.
- DONE (WRAP=0 only): `digits` hold at 0000. Exit only via `load` or `reset`.
- `load`:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - On accept: `digits` ← `load_value`, next state IDLE, `expired` cleared, prescaler cleared.
  - Rejected if `load_value` is invalid: any ones digit > 9 or any tens digit > 5. On rejection, state and value are unchanged.
- Priority in a single cycle: `reset` > `load` > `pause` > `start`. When `start` and `pause` are both high in RUN or PAUSE, the next state is PAUSE.
- Decrement, per digit with borrow:
  - sec_ones 0 → 9, borrow.
  - sec_tens 0 → 5, borrow.
  - min_ones 0 → 9, borrow.
  - min_tens 0 → 5.
  - Otherwise the digit decrements by 1.
- Expiry, WRAP=0: the step that produces 0000 moves the state to DONE and sets `expired` = 1 on the same edge. `expired` stays high until `load` or `reset`.
- Expiry, WRAP=1:
  - The step that produces 0000 pulses `expired` for one cycle; the state stays RUN.
  - The next step gives 5959.
  - DONE is never entered, except through the IDLE `start` with 0000 case.
- Outputs never contain non-BCD digits.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `running` goes high on the edge that samples `start`.
- First decrement happens `TICK_DIV` cycles after RUN entry from IDLE.
- `tick` and the updated `digits` appear on the same edge.
- Pause/resume preserves the sub-second phase: total RUN cycles per step is exactly `TICK_DIV`.
- `load` takes effect on the next edge; `running` goes to 0 on that same edge.
- `reset` asserted mid-RUN returns all reset values on the next edge, regardless of other inputs.

## Configuration
- Macro: `COUNTDOWN_BLINK_EN`.
- Defined:
  - In DONE the prescaler keeps running.
  - `blank` toggles at every prescaler terminal count.
  - `blank` is 0 outside DONE and is cleared on leaving DONE.
  - `tick` does not pulse in DONE.
- Undefined:
  - `blank` is constant 0.
  - Prescaler is held at 0 in DONE.

## Test plan
- TICK_DIV=4, reset, `load` 16'h0003, `start`:
  - `tick` every 4 cycles.
  - `digits` go 0003 → 0002 → 0001 → 0000.
  - `expired`=1 and `running`=0 on the edge that produces 0000.
  - `digits` then hold for 20 cycles.
- Borrow chain: `load` 16'h1000, run one step → 0959; `load` 16'h0100, run one step → 0059.
- Pause phase: start, pause after 2 RUN cycles for 10 cycles, resume → next `tick` exactly 2 RUN cycles after resume; `digits` frozen during pause.
- Invalid and blocked loads:
  - `load` 16'h0A00 in IDLE → ignored.
  - `load` 16'h0060 in IDLE → ignored.
  - `load` 16'h1234 during RUN → ignored.
  - `load` 16'h1234 in PAUSE → accepted, state IDLE.
- WRAP=1, `load` 16'h0001, start:
  - Sequence 0001 → 0000 → 5959.
  - `expired` high for exactly one cycle at 0000.
  - `running` stays 1 throughout.
- Reset mid-RUN:
  - Assert `reset` with `start`=1 → next edge `digits`=5959, `running`=0, `tick`=0.
  - With `COUNTDOWN_BLINK_EN`, after expiry `blank` toggles every 4 cycles and clears on `load`.
